// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the single-bit serial link.
// The transmitter and the receive-side pattern detectors both import this package.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } statetype;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Parallel word handshake into the serial transmitter.
// The producer drives data/valid and the transmitter answers with ready.
interface serial_pattern_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/serial_pattern_tx_bit_timer.sv
// Per-bit down-counter: loads BIT_CYCLES-1 and counts to 0.
// tick marks the last clock of the current serial bit.
module bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tick
);
    localparam int            TW     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(BIT_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        timer_d = timer_q;
        if (load)
            timer_d = RELOAD;
        else if (timer_q != '0)
            timer_d = timer_q - TW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            timer_q <= '0;
        else
            timer_q <= timer_d;
    end

    assign tick = (timer_q == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: start bit (0), WIDTH data bits LSB first, stop bit (1).
// The line idles high and is driven from a register.
module serial_pattern_tx
    import serial_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_pattern_tx_if.slave   bus,
    output logic                 a,
    output logic                 busy,
    output logic                 done
);
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);

    statetype         state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             tick;
    logic             load;
    logic             accept;

    bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .tick  (tick)
    );

    assign bus.ready = (state_q == IDLE);
    assign accept    = bus.valid && bus.ready;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    shift_d = bus.data;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    load    = 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                    load    = 1'b1;
                    if (cnt_d == LAST_BIT)
                        state_d = STOP;
                end
            end
            STOP: begin
                if (tick)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The line level is chosen from the next state so a lands in the same edge as the state change.
    always_comb begin
        case (state_d)
            START:   a_d = START_LEVEL;
            DATA:    a_d = shift_d[0];
            default: a_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            // NOTE: the shift register is cleared on reset so an aborted frame leaves no residue.
            shift_q <= '0;
            cnt_q   <= '0;
            a_q     <= IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
        end
    end

    assign a    = a_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == STOP) && tick;

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial frame transmitter: accepts a parallel word over a valid/ready handshake and drives it onto a single serial line, framed by a start bit (0) and a stop bit (1), with the line idling high. It is the transmit end of the single-bit serial link whose receive side runs the team's pattern detectors. Its falling start edge followed by data gives the downstream "01"-style detectors a defined frame boundary.

## Interface
- WIDTH, 8: data bits per frame (>= 1).
- BIT_CYCLES, 4: clock cycles each serial bit is held (>= 1).
- clk  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- data  input  WIDTH  word to transmit; sampled only on an accepted handshake.
- valid  input  1  data is offered.
- ready  output  1  block can accept a word; high only in IDLE.
- a  output  1  serial line, registered; idle level 1.
- busy  output  1  high while a frame is in progress (START, DATA or STOP).
- done  output  1  one-cycle pulse on the final clock of the stop bit.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE: a=1, ready=1, busy=0. valid&&ready at a rising edge latches data into the shift register, loads the bit timer and the bit counter, and moves to START.
- START: a=0 for BIT_CYCLES cycles, then DATA with bit index 0.
- DATA: a = shift register LSB. The register shifts right after each BIT_CYCLES cycles. After WIDTH bits have been sent, go to STOP.
- STOP: a=1 for BIT_CYCLES cycles. done=1 on the last of those cycles, then IDLE.
- The bit timer counts BIT_CYCLES-1 down to 0. A bit ends when the timer reads 0. It reloads on every bit boundary.
- The bit counter is $clog2(WIDTH+1) bits wide. It counts data bits sent and does not wrap within a frame.
- valid is ignored outside IDLE. data changes during a frame have no effect.
- Reset (reset=0) at any time, including mid-frame, forces the following outputs immediately and asynchronously: state=IDLE, a=1, ready=1, busy=0, done=0. The shift register and counters are cleared. A partial frame is abandoned, and no done pulse is produced for it.
- Illegal state encodings fall back to IDLE.

## Timing
- Reset values: a=1, ready=1, busy=0, done=0.
- Handshake at edge E0: a=0 and busy=1 from E0 onward. ready=0 from E0 until the frame ends.
- Start bit occupies cycles 1..BIT_CYCLES after E0. Data bit k occupies cycles (k+1)*BIT_CYCLES+1 .. (k+2)*BIT_CYCLES.
- Stop bit ends at cycle (WIDTH+2)*BIT_CYCLES, which is the done cycle. Frame length is (WIDTH+2)*BIT_CYCLES clocks.
- ready rises on the edge after the done cycle. There is at least 1 idle cycle (a=1) between back-to-back frames. Frame period with valid held high is (WIDTH+2)*BIT_CYCLES+1.
- Corner case BIT_CYCLES=1: every bit lasts exactly one clock, with no stall cycles.
- done and busy are both high in the done cycle. busy falls together with the return to IDLE.

## Structure
- Shared package serial_pkg holds:
  - the statetype enum {IDLE, START, DATA, STOP} (logic [1:0]);
  - IDLE_LEVEL=1'b1;
  - START_LEVEL=1'b0.
- The receiver side imports the same package.
- Sub-module bit_timer (parameter BIT_CYCLES) has ports clk, reset, load, and output tick (timer==0). Only the down-counter lives in it. The FSM, shift register and bit counter stay in serial_pattern_tx.

## Test plan
- **Reset:** hold reset=0 for 3 cycles, mid-idle and again mid-frame. Required: a=1, ready=1, busy=0, done=0 immediately; no done pulse afterwards.
- **Single frame:** WIDTH=8, BIT_CYCLES=4, data=8'hA5, valid for 1 cycle. Required a bit sequence of 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles long; done at cycle 40 after the accept; ready=1 at cycle 41.
- **Back-to-back:** valid held high with 8'h00 then 8'hFF. Required:
  - 8'h00 frame: a low for 36 cycles (start + 8 data bits), then stop high.
  - Exactly 1 idle cycle, then the second start bit.
  - 8'hFF frame: a low for 4 cycles (start only), then high for 36 cycles (8 data bits + stop).
- **Data/valid ignored when busy:** change data and pulse valid during DATA. Required: transmitted bits still match the latched word; ready stays 0.
- **BIT_CYCLES=1, WIDTH=1:** data=1. Required: a = 0,1,1 on consecutive cycles; done on the 3rd cycle.
- **Reset mid-DATA:** reset for 1 cycle, then a new valid with 8'h3C. Required: a clean frame for 8'h3C with no residue of the aborted frame.
